// File: rtl/control_sequencer_if.sv
// Signal bundle between the control sequencer, instruction memory, the decoders and the datapath.
// master = sequencer side, slave = surrounding fetch/decode/datapath side.

// Handshake: instr_in is taken only on a rising edge where fetch_req=1 and instr_valid=1
// (fetch_req already includes stall=0). While it is not taken, memory keeps instr_valid and
// instr_in steady. stall=1 freezes the sequencer for that cycle and discards the decoder word.
interface control_sequencer_if;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        stall;
  logic [32:0] cw_in;
  logic [4:0]  status_in;
  logic [31:0] I;
  logic [1:0]  state;
  logic [4:0]  status;
  logic [32:0] cw_out;
  logic        fetch_req;
  logic        fault;

  modport master (
    input  instr_in, instr_valid, stall, cw_in, status_in,
    output I, state, status, cw_out, fetch_req, fault
  );

  modport slave (
    output instr_in, instr_valid, stall, cw_in, status_in,
    input  I, state, status, cw_out, fetch_req, fault
  );
endinterface

// File: rtl/control_sequencer.sv
// Fetch/execute sequencer feeding the instruction decoders and gating their control word to the datapath.
// Optional macro RETIRE_COUNT_EN adds a 32-bit retired-instruction counter output.
module control_sequencer (
  input  logic                 clock,
  input  logic                 reset_n,
  control_sequencer_if.master  bus,
  output logic [1:0]           fsm_state_o
`ifdef RETIRE_COUNT_EN
  ,
  output logic [31:0]          retired
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_FAULT = 2'd2
  } fsm_t;

  localparam logic [32:0] CW_NOP = 33'd0;

  fsm_t        fsm_q, fsm_d;
  logic [31:0] instr_q, instr_d;
  logic [1:0]  state_q, state_d;
  logic [4:0]  status_q, status_d;
  logic [1:0]  step_q, step_d;

  logic [1:0]  ns;
  logic        status_load;
  logic        retire;

  assign ns          = bus.cw_in[1:0];
  assign status_load = bus.cw_in[2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q    <= S_FETCH;
      instr_q  <= 32'd0;
      state_q  <= 2'd0;
      status_q <= 5'd0;
      step_q   <= 2'd0;
    end else begin
      fsm_q    <= fsm_d;
      instr_q  <= instr_d;
      state_q  <= state_d;
      status_q <= status_d;
      step_q   <= step_d;
    end
  end

  always_comb begin
    fsm_d         = fsm_q;
    instr_d       = instr_q;
    state_d       = state_q;
    status_d      = status_q;
    step_d        = step_q;
    bus.cw_out    = CW_NOP;
    bus.fetch_req = 1'b0;
    retire        = 1'b0;

    unique case (fsm_q)
      S_FETCH: begin
        if (!bus.stall) begin
          bus.fetch_req = 1'b1;
          if (bus.instr_valid) begin
            instr_d = bus.instr_in;
            state_d = 2'd0;
            step_d  = 2'd0;
            fsm_d   = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        // A stalled cycle discards the word; the decoder re-presents it since I/state hold.
        if (!bus.stall) begin
          bus.cw_out = bus.cw_in;
          if (status_load) begin
            status_d = bus.status_in;
          end
          if (ns == 2'd0) begin
            state_d = 2'd0;
            fsm_d   = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = ns;
            step_d  = step_q + 2'd1;
            if (step_q == 2'd3) begin
              fsm_d = S_FAULT;
            end
          end
        end
      end

      S_FAULT: begin
        fsm_d = S_FAULT;
      end

      default: begin
        fsm_d = S_FAULT;
      end
    endcase
  end

  assign bus.I       = instr_q;
  assign bus.state   = state_q;
  assign bus.status  = status_q;
  assign bus.fault   = (fsm_q == S_FAULT);
  assign fsm_state_o = fsm_q;

`ifdef RETIRE_COUNT_EN
  logic [31:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (retire) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retired_q <= 32'd0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a per-cycle vector table plus hand-written fault and async-reset sequences.
// Build with +define+RETIRE_COUNT_EN to also exercise the retired counter.
module tb_control_sequencer;

  logic        clock;
  logic        reset_n;
  logic [1:0]  fsm_state_o;
`ifdef RETIRE_COUNT_EN
  logic [31:0] retired;
`endif

  control_sequencer_if bus ();

  control_sequencer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .fsm_state_o (fsm_state_o)
`ifdef RETIRE_COUNT_EN
    ,
    .retired     (retired)
`endif
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic        iv;
    logic        st;
    logic [32:0] cw;
    logic [4:0]  si;
    logic [31:0] e_i;
    logic [1:0]  e_state;
    logic [4:0]  e_status;
    logic [32:0] e_cw;
    logic        e_fetch;
    logic        e_fault;
  } vec_t;

  vec_t vecs[$];
  // {I, state, status, cw_out, fetch_req, fault}
  logic [73:0] exp_q[$];

  localparam logic [29:0] U1 = 30'h2AAA_5555;
  localparam logic [29:0] U2 = 30'h1555_AAAA;
  localparam logic [29:0] U3 = 30'h0123_4567;

  function automatic logic [32:0] mk_cw(input logic [29:0] up, input logic sl, input logic [1:0] ns);
    return {up, sl, ns};
  endfunction

  function automatic void add_vec(input logic [31:0] instr, input logic iv, input logic st,
                                  input logic [32:0] cw, input logic [4:0] si,
                                  input logic [31:0] e_i, input logic [1:0] e_state,
                                  input logic [4:0] e_status, input logic [32:0] e_cw,
                                  input logic e_fetch);
    vec_t v;
    v.instr = instr; v.iv = iv; v.st = st; v.cw = cw; v.si = si;
    v.e_i = e_i; v.e_state = e_state; v.e_status = e_status; v.e_cw = e_cw;
    v.e_fetch = e_fetch; v.e_fault = 1'b0;
    vecs.push_back(v);
  endfunction

  // driver tasks
  task automatic drive(input logic [31:0] instr, input logic iv, input logic st,
                       input logic [32:0] cw, input logic [4:0] si);
    bus.instr_in    = instr;
    bus.instr_valid = iv;
    bus.stall       = st;
    bus.cw_in       = cw;
    bus.status_in   = si;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp_v, $time);
    end
  endtask

  // scoreboard: pop the expected record and compare every output field
  task automatic score(input int idx);
    logic [73:0] e;
    string tag;
    e = exp_q.pop_front();
    tag = $sformatf("v%0d", idx);
    chk({tag, ".I"},         {1'b0, bus.I},           {1'b0, e[73:42]});
    chk({tag, ".state"},     {31'd0, bus.state},      {31'd0, e[41:40]});
    chk({tag, ".status"},    {28'd0, bus.status},     {28'd0, e[39:35]});
    chk({tag, ".cw_out"},    bus.cw_out,              e[34:2]);
    chk({tag, ".fetch_req"}, {32'd0, bus.fetch_req},  {32'd0, e[1]});
    chk({tag, ".fault"},     {32'd0, bus.fault},      {32'd0, e[0]});
  endtask

  initial begin
    // vector table: instr, iv, st, cw, si | I, state, status, cw_out, fetch_req
    add_vec(32'h9100_0421, 1, 0, mk_cw(U1,0,2'd0), 5'd0,   32'h0,         2'd0, 5'd0,     33'd0,            1);
    add_vec(32'h0,         0, 0, mk_cw(U1,0,2'd0), 5'd0,   32'h9100_0421, 2'd0, 5'd0,     mk_cw(U1,0,2'd0), 0);
    add_vec(32'h0,         0, 0, mk_cw(U1,0,2'd0), 5'd0,   32'h9100_0421, 2'd0, 5'd0,     33'd0,            1);
    add_vec(32'h1234_5678, 1, 0, mk_cw(U2,0,2'd1), 5'd0,   32'h9100_0421, 2'd0, 5'd0,     33'd0,            1);
    add_vec(32'h0,         0, 0, mk_cw(U2,0,2'd1), 5'd0,   32'h1234_5678, 2'd0, 5'd0,     mk_cw(U2,0,2'd1), 0);
    add_vec(32'h0,         0, 0, mk_cw(U2,0,2'd2), 5'd0,   32'h1234_5678, 2'd1, 5'd0,     mk_cw(U2,0,2'd2), 0);
    add_vec(32'h0,         0, 0, mk_cw(U2,0,2'd0), 5'd0,   32'h1234_5678, 2'd2, 5'd0,     mk_cw(U2,0,2'd0), 0);
    add_vec(32'h0,         0, 0, mk_cw(U2,0,2'd0), 5'd0,   32'h1234_5678, 2'd0, 5'd0,     33'd0,            1);
    add_vec(32'hCAFE_0001, 1, 0, mk_cw(U3,1,2'd1), 5'b10110, 32'h1234_5678, 2'd0, 5'd0,   33'd0,            1);
    add_vec(32'h0,         0, 1, mk_cw(U3,1,2'd1), 5'b10110, 32'hCAFE_0001, 2'd0, 5'd0,   33'd0,            0);
    add_vec(32'h0,         0, 0, mk_cw(U3,1,2'd1), 5'b10110, 32'hCAFE_0001, 2'd0, 5'd0,   mk_cw(U3,1,2'd1), 0);
    add_vec(32'h0,         0, 0, mk_cw(U3,1,2'd0), 5'b00011, 32'hCAFE_0001, 2'd1, 5'b10110, mk_cw(U3,1,2'd0), 0);
    add_vec(32'hDEAD_BEEF, 1, 1, mk_cw(U1,0,2'd0), 5'd0,   32'hCAFE_0001, 2'd0, 5'b00011, 33'd0,            0);
    add_vec(32'hDEAD_BEEF, 1, 0, mk_cw(U1,0,2'd0), 5'd0,   32'hCAFE_0001, 2'd0, 5'b00011, 33'd0,            1);
    add_vec(32'h0,         0, 0, mk_cw(U1,0,2'd0), 5'b11111, 32'hDEAD_BEEF, 2'd0, 5'b00011, mk_cw(U1,0,2'd0), 0);
    add_vec(32'h0,         0, 0, mk_cw(U1,0,2'd0), 5'd0,   32'hDEAD_BEEF, 2'd0, 5'b00011, 33'd0,            1);

    // reset values, checked before any clock edge
    reset_n = 1'b0;
    drive(32'h0, 0, 0, 33'd0, 5'd0);
    #1;
    chk("rst.I",         {1'b0, bus.I},          33'd0);
    chk("rst.state",     {31'd0, bus.state},     33'd0);
    chk("rst.status",    {28'd0, bus.status},    33'd0);
    chk("rst.cw_out",    bus.cw_out,             33'd0);
    chk("rst.fetch_req", {32'd0, bus.fetch_req}, 33'd1);
    chk("rst.fault",     {32'd0, bus.fault},     33'd0);
`ifdef RETIRE_COUNT_EN
    chk("rst.retired",   {1'b0, retired},        33'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    next_cycle();

    // table-driven phase: one vector per clock cycle
    foreach (vecs[i]) begin
      drive(vecs[i].instr, vecs[i].iv, vecs[i].st, vecs[i].cw, vecs[i].si);
      exp_q.push_back({vecs[i].e_i, vecs[i].e_state, vecs[i].e_status, vecs[i].e_cw,
                       vecs[i].e_fetch, vecs[i].e_fault});
      @(negedge clock);
      score(i);
      next_cycle();
    end
`ifdef RETIRE_COUNT_EN
    chk("tbl.retired", {1'b0, retired}, 33'd4);
`endif

    // step limit: NS=01 held forever faults after the 4th EXEC cycle
    drive(32'h0F0F_0F0F, 1, 0, mk_cw(U2,0,2'd1), 5'd0);
    @(negedge clock);
    chk("flt.fetch_req0", {32'd0, bus.fetch_req}, 33'd1);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      drive(32'h0, 0, 0, mk_cw(U2,0,2'd1), 5'd0);
      @(negedge clock);
      chk($sformatf("flt.exec%0d.cw_out", k), bus.cw_out, mk_cw(U2,0,2'd1));
      chk($sformatf("flt.exec%0d.state", k), {31'd0, bus.state}, (k == 0) ? 33'd0 : 33'd1);
      chk($sformatf("flt.exec%0d.fault", k), {32'd0, bus.fault}, 33'd0);
      next_cycle();
    end
    for (int k = 0; k < 3; k++) begin
      drive(32'hAAAA_AAAA, 1, 0, mk_cw(U2,1,2'd0), 5'b11111);
      @(negedge clock);
      chk($sformatf("flt.hold%0d.fault", k), {32'd0, bus.fault}, 33'd1);
      chk($sformatf("flt.hold%0d.cw_out", k), bus.cw_out, 33'd0);
      chk($sformatf("flt.hold%0d.fetch_req", k), {32'd0, bus.fetch_req}, 33'd0);
      chk($sformatf("flt.hold%0d.I", k), {1'b0, bus.I}, {1'b0, 32'h0F0F_0F0F});
      next_cycle();
    end
    drive(32'h0, 0, 0, 33'd0, 5'd0);
    reset_n = 1'b0;
    #1;
    chk("flt.rst.fault",     {32'd0, bus.fault},     33'd0);
    chk("flt.rst.fetch_req", {32'd0, bus.fetch_req}, 33'd1);
    chk("flt.rst.status",    {28'd0, bus.status},    33'd0);
    @(negedge clock);
    reset_n = 1'b1;
    next_cycle();

    // asynchronous reset in the middle of an EXEC cycle with state=10
    drive(32'h55AA_33CC, 1, 0, mk_cw(U1,0,2'd2), 5'd0);
    next_cycle();
    drive(32'h0, 0, 0, mk_cw(U1,0,2'd2), 5'd0);
    next_cycle();
    #2;
    chk("arst.pre.state",  {31'd0, bus.state}, 33'd2);
    chk("arst.pre.cw_out", bus.cw_out,         mk_cw(U1,0,2'd2));
    reset_n = 1'b0;
    #1;
    chk("arst.state",     {31'd0, bus.state},     33'd0);
    chk("arst.I",         {1'b0, bus.I},          33'd0);
    chk("arst.cw_out",    bus.cw_out,             33'd0);
    chk("arst.fetch_req", {32'd0, bus.fetch_req}, 33'd1);
    @(negedge clock);
    reset_n = 1'b1;
    next_cycle();
    drive(32'h0000_0077, 1, 0, mk_cw(U3,0,2'd0), 5'd0);
    next_cycle();
    drive(32'h0, 0, 0, mk_cw(U3,0,2'd0), 5'd0);
    @(negedge clock);
    chk("arst.resume.I",      {1'b0, bus.I}, {1'b0, 32'h0000_0077});
    chk("arst.resume.cw_out", bus.cw_out,    mk_cw(U3,0,2'd0));
`ifdef RETIRE_COUNT_EN
    chk("ret.before", {1'b0, retired}, 33'd0);
`endif
    next_cycle();
`ifdef RETIRE_COUNT_EN
    chk("ret.one", {1'b0, retired}, 33'd1);
    // wrap: preload the counter to all ones, then retire one more instruction
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    drive(32'h0000_0088, 1, 0, mk_cw(U3,0,2'd0), 5'd0);
    next_cycle();
    chk("ret.preload", {1'b0, retired}, {1'b0, 32'hFFFF_FFFF});
    drive(32'h0, 0, 0, mk_cw(U3,0,2'd0), 5'd0);
    next_cycle();
    chk("ret.wrap", {1'b0, retired}, 33'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Instruction sequencer directly upstream of the instruction decoders. Fetches a 32-bit instruction into an instruction register and presents it, with the current 2-bit execution state and latched 5-bit status, to the decoders. Consumes the selected decoder's 33-bit control word. Its NS and status_load fields drive the sequencer's own state and status registers, and the word is forwarded (or forced to a no-op) to the datapath.

## Interface
- No parameters.
- clock  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- instr_in  in  32  instruction word from instruction memory at current PC.
- instr_valid  in  1  instr_in valid this cycle.
- stall  in  1  freeze request from datapath/memory.
- cw_in  in  33  control word from the selected decoder.
  - Packed {alu_en, alu_bs, alu_fs[4:0], rfb_en, sa[4:0], sb[4:0], wa[4:0], reg_w, ram_en, ram_w, pc_en, pc_fs[1:0], pc_in_sel, status_load, NS[1:0]}.
  - status_load = cw_in[2]; NS = cw_in[1:0].
- status_in  in  5  ALU flags produced this cycle.
- I  out  32  instruction register to decoders.
- state  out  2  current execution state to decoders.
- status  out  5  latched status register to decoders.
- cw_out  out  33  control word to datapath.
- fetch_req  out  1  instruction fetch request.
- fault  out  1  sticky sequencing fault.

## Operation
- FSM states:
  - FETCH: reset state.
  - EXEC.
  - FAULT.
- FETCH:
  - fetch_req=1 when stall=0.
  - cw_out = 33'b0 (NOP: no writes, pc_fs=00 hold).
  - On instr_valid=1 and stall=0: I<=instr_in, state<=00, step<=0, go EXEC.
- EXEC:
  - cw_out=cw_in, fetch_req=0, instr_valid ignored.
  - Each non-stalled cycle: if cw_in[2]=1, status<=status_in.
  - If NS=00: go FETCH (instruction retired), state<=00.
  - Else: state<=NS, step<=step+1.
  - If step==3 and NS!=00: go FAULT, fault<=1.
- FAULT:
  - cw_out=NOP, fetch_req=0, fault=1.
  - Exits only on reset.
- step: 2-bit internal counter; limits an instruction to at most 4 EXEC cycles.
- stall=1 (any state):
  - All registers hold, cw_out=NOP, fetch_req=0.
  - A status_load or NS in that cycle is discarded. The decoder re-presents the same word next cycle, since I and state are unchanged.
- I and status hold across FETCH; status is not cleared per instruction.

## Timing
- Reset values: I=0, state=00, status=00000, cw_out=0, fetch_req=1 (FETCH, stall permitting), fault=0, step=0, FSM=FETCH.
- reset_n low mid-instruction: immediate return to reset values, asynchronously. The partially executed instruction is abandoned.
- Fetch latency: instr_valid sampled at edge N → I valid and FSM=EXEC after edge N; first cw_out from cw_in in cycle N+1.
- Minimum 2 cycles per instruction (1 FETCH + 1 EXEC); maximum 5 (1 FETCH + 4 EXEC).
- cw_out is combinational from cw_in, FSM, and stall: zero added latency in EXEC.
- status update: visible on the status output the cycle after the status_load=1 EXEC cycle.
- Simultaneous events:
  - instr_valid and stall in FETCH: instruction not captured; memory must hold instr_valid.
  - NS=00 with status_load=1: status latched, and FETCH entered on the same edge.

## Configuration
- RETIRE_COUNT_EN defined:
  - Adds output retired [31:0], reset 0.
  - Increments on each EXEC cycle with NS=00 and stall=0.
  - Wraps FFFFFFFF→0.
- RETIRE_COUNT_EN undefined: port and counter absent; behaviour otherwise identical.

## Test plan
- Reset then instr_in=32'h91000421, instr_valid=1, cw_in NS=00 status_load=0 → I=91000421 after 1 edge, cw_out=cw_in for exactly one cycle, FETCH again, status unchanged 00000.
- Multi-state: cw_in NS sequence 01,10,00 → state output 00,01,10 across 3 EXEC cycles, then FETCH; retired=1 with RETIRE_COUNT_EN.
- status_load=1 with status_in=5'b10110 in EXEC → status=10110 next cycle; identical cycle with stall=1 → status stays old value, cw_out=0.
- NS=01 held constantly → fault=1 after 4th EXEC cycle, cw_out=0, fetch_req=0 until reset_n pulse, then fault=0.
- reset_n asserted mid-EXEC (state=10) → state=00, I=0, cw_out=0 immediately without a clock edge; fetch resumes after release.
- RETIRE_COUNT_EN with counter preloaded to FFFFFFFF via 2^32 retires (or force) → next retire gives 00000000.
